bufm_id_mgr: RTL

BUFM_ID_MGR -- requirements
Module: bufm_id_mgr

---
 rtl/bufm_id_mgr.sv | 96 +++++++++
 1 files changed

// File: rtl/bufm_id_mgr.sv
// Packet buffer ID manager: a circular free-list of buffer IDs plus an allocated
// bitmap; grants IDs on alloc requests and takes them back from the output side.
module bufm_id_mgr #(
   parameter int BUF_NUM = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_bufm_alloc_req,
   output logic       out_bufm_alloc_ack,
   output logic       out_bufm_alloc_nack,
   output logic [7:0] out_bufm_ID,
   input  logic [7:0] in_bufm_free_id,
   input  logic       in_bufm_free_wr,
   output logic [4:0] out_bufm_ID_count,
   output logic       out_bufm_ready,
   output logic       out_bufm_err
);

   localparam logic [0:0] INIT_S   = 1'b0;
   localparam logic [0:0] RUN_S    = 1'b1;
   localparam logic [3:0] LAST_ID  = 4'(BUF_NUM - 1);
   localparam logic [7:0] ID_LIMIT = 8'(BUF_NUM);

   logic [0:0]         state;
   logic [3:0]         fifo_mem [BUF_NUM];
   logic [3:0]         rd_ptr;
   logic [3:0]         wr_ptr;
   logic [BUF_NUM-1:0] alloc_map;
   logic [BUF_NUM-1:0] alloc_map_nxt;
   logic [4:0]         free_cnt;
   logic [4:0]         free_cnt_nxt;
   logic [3:0]         head_id;
   logic [3:0]         free_id4;
   logic               run;
   logic               alloc_ok;
   logic               free_ok;
   logic               fifo_wr;
   logic [3:0]         fifo_wdata;

   function automatic logic [3:0] next_ptr(input logic [3:0] p);
      return (p == LAST_ID) ? 4'd0 : p + 4'd1;
   endfunction

   // Request decode: the free is judged against the bitmap as it stood before this cycle
   always_comb begin
      run        = (state == RUN_S);
      head_id    = fifo_mem[rd_ptr];
      free_id4   = in_bufm_free_id[3:0];
      alloc_ok   = in_bufm_alloc_req && run && (free_cnt != 5'd0);
      free_ok    = in_bufm_free_wr && run && (in_bufm_free_id < ID_LIMIT) && alloc_map[free_id4];
      fifo_wr    = !run || free_ok;
      fifo_wdata = run ? free_id4 : wr_ptr;

      alloc_map_nxt = alloc_map;
      if (alloc_ok) alloc_map_nxt[head_id] = 1'b1;
      if (free_ok)  alloc_map_nxt[free_id4] = 1'b0;

      free_cnt_nxt = free_cnt + {4'd0, fifo_wr} - {4'd0, alloc_ok};
   end

   assign out_bufm_ready    = run;
   assign out_bufm_ID_count = free_cnt;

   // Registered state and one-cycle response pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state               <= INIT_S;
         rd_ptr              <= 4'd0;
         wr_ptr              <= 4'd0;
         alloc_map           <= '0;
         free_cnt            <= 5'd0;
         out_bufm_alloc_ack  <= 1'b0;
         out_bufm_alloc_nack <= 1'b0;
         out_bufm_err        <= 1'b0;
         out_bufm_ID         <= 8'h00;
      end else begin
         out_bufm_alloc_ack  <= alloc_ok;
         out_bufm_alloc_nack <= in_bufm_alloc_req && !alloc_ok;
         out_bufm_err        <= in_bufm_free_wr && !free_ok;
         alloc_map           <= alloc_map_nxt;
         free_cnt            <= free_cnt_nxt;
         if (alloc_ok) begin
            out_bufm_ID <= {4'd0, head_id};
            rd_ptr      <= next_ptr(rd_ptr);
         end
         if (fifo_wr) wr_ptr <= next_ptr(wr_ptr);
         if (!run && (wr_ptr == LAST_ID)) state <= RUN_S;
      end
   end

   // Free-list storage holds data only, so it carries no reset
   always_ff @(posedge clk) begin
      if (fifo_wr) fifo_mem[wr_ptr] <= fifo_wdata;
   end

endmodule
